f1_reaction_ctrl: RTL

- Race controller that sequences the F1 start-lights unit.
- On a start press it pulses `trigger` to the lights unit, then watches for a jump start while the lights are counting.
- Once the lights go out, it measures the driver's reaction time in ticks and keeps a best-time record.
- Sits above the lights/delay datapath. Consumes that unit's `time_out` pulse and drives its `trigger` input.

---
 rtl/f1_pkg.sv | 19 +
 rtl/tick_div.sv | 34 +++
 rtl/f1_reaction_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/f1_pkg.sv
// Shared definitions for the F1 reaction-time controller.
// Contents: controller state encoding and the 2-bit result status codes.
// Imported by f1_reaction_ctrl and tick_div.
package f1_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_LIGHTS,
    S_TIMING,
    S_DONE
  } ctrl_state_t;

  localparam logic [1:0] ST_NONE   = 2'd0;
  localparam logic [1:0] ST_OK     = 2'd1;
  localparam logic [1:0] ST_JUMP   = 2'd2;
  localparam logic [1:0] ST_MISSED = 2'd3;

endpackage

// File: rtl/tick_div.sv
// Tick divider: emits a one-cycle tick every DIV enabled cycles.
// Ports: clk, rst (async active-low), clr (sync clear, wins over en),
//        en (count enable), tick (combinational, high on the last count).
module tick_div
  import f1_pkg::*;
#(
  parameter int DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + W'(1);
    end
  end

  // A clear cycle restarts the period, so it must not also produce a tick.
  assign tick = en & ~clr & (count == LAST);

endmodule

// File: rtl/f1_reaction_ctrl.sv
// Race controller above the start-lights unit: triggers the light sequence,
// flags jump starts, times the driver's reaction in ticks and tracks the best.
// Ports: clk, rst (async active-low); start_btn/react_btn level buttons
//        (rising edge used); lights_out pulse in; trigger pulse out; busy;
//        react_time/status/result_valid result; best_time record.
module f1_reaction_ctrl
  import f1_pkg::*;
#(
  parameter int TICK_DIV  = 1000,
  parameter int CNT_W     = 12,
  parameter int MAX_REACT = 2000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_btn,
  input  logic             react_btn,
  input  logic             lights_out,
  output logic             trigger,
  output logic             busy,
  output logic [CNT_W-1:0] react_time,
  output logic             result_valid,
  output logic [1:0]       status,
  output logic [CNT_W-1:0] best_time
);

  // The saturating counter relies on MAX_REACT being representable.
  if (MAX_REACT < 1 || MAX_REACT >= (1 << CNT_W)) begin : g_bad_max_react
    $error("MAX_REACT must be in 1 .. 2**CNT_W-1");
  end

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_REACT);

  ctrl_state_t      state, state_n;
  logic             start_q, react_q;
  logic             start_edge, react_edge;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic             tick;
  logic             div_clr, div_en;

  logic             trigger_n, busy_n, result_valid_n;
  logic [1:0]       status_n;
  logic [CNT_W-1:0] react_time_n, best_time_n;

  assign start_edge = start_btn & ~start_q;
  assign react_edge = react_btn & ~react_q;

  // Divider runs only while timing and restarts on the cycle TIMING is entered.
  assign div_en  = (state == S_TIMING);
  assign div_clr = (state != S_TIMING) && (state_n == S_TIMING);

  tick_div #(
    .DIV (TICK_DIV)
  ) u_tick_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (div_clr),
    .en   (div_en),
    .tick (tick)
  );

  // Count including this cycle's tick; a react in the same cycle sees it.
  assign cnt_inc = (tick && (cnt != MAX_C)) ? cnt + CNT_W'(1) : cnt;

  always_comb begin
    state_n        = state;
    cnt_n          = cnt;
    trigger_n      = 1'b0;
    result_valid_n = 1'b0;
    busy_n         = busy;
    status_n       = status;
    react_time_n   = react_time;
    best_time_n    = best_time;

    case (state)
      S_IDLE: begin
        if (start_edge) begin
          state_n   = S_ARM;
          trigger_n = 1'b1;
          busy_n    = 1'b1;
        end
      end

      S_ARM: begin
        state_n = S_LIGHTS;
      end

      S_LIGHTS: begin
        // Jump start has priority over a same-cycle lights_out.
        if (react_edge) begin
          state_n        = S_DONE;
          status_n       = ST_JUMP;
          react_time_n   = '0;
          result_valid_n = 1'b1;
          busy_n         = 1'b0;
        end else if (lights_out) begin
          state_n = S_TIMING;
          cnt_n   = '0;
        end
      end

      S_TIMING: begin
        cnt_n = cnt_inc;
        // A react on the same cycle the limit is reached still counts as ok.
        if (react_edge) begin
          state_n        = S_DONE;
          status_n       = ST_OK;
          react_time_n   = cnt_inc;
          result_valid_n = 1'b1;
          busy_n         = 1'b0;
          if (cnt_inc < best_time) begin
            best_time_n = cnt_inc;
          end
        end else if (cnt_inc == MAX_C) begin
          state_n        = S_DONE;
          status_n       = ST_MISSED;
          react_time_n   = MAX_C;
          result_valid_n = 1'b1;
          busy_n         = 1'b0;
        end
      end

      S_DONE: begin
        if (start_edge) begin
          state_n   = S_ARM;
          trigger_n = 1'b1;
          busy_n    = 1'b1;
        end
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      start_q      <= 1'b0;
      react_q      <= 1'b0;
      cnt          <= '0;
      trigger      <= 1'b0;
      busy         <= 1'b0;
      react_time   <= '0;
      result_valid <= 1'b0;
      status       <= ST_NONE;
      best_time    <= '1;
    end else begin
      state        <= state_n;
      start_q      <= start_btn;
      react_q      <= react_btn;
      cnt          <= cnt_n;
      trigger      <= trigger_n;
      busy         <= busy_n;
      react_time   <= react_time_n;
      result_valid <= result_valid_n;
      status       <= status_n;
      best_time    <= best_time_n;
    end
  end

endmodule
